seq_counter_ctrl: RTL and testbench
===================================

Name: seq_counter_ctrl

Overview:
Sequencer for the team's small custom-sequence state counters. It holds a programmable table of up to DEPTH state codes and steps an output state register through them at a programmable rate. It supports one-shot or looping runs, hold/stop control and a done pulse. It sits between a host/test controller and any logic that consumes a WIDTH-bit sequenced state, replacing hard-wired SR-flip-flop sequence counters with a configurable one.

Parameters:
WIDTH, 3, width of each state code and of Q
DEPTH, 8, number of table entries (power of two)
PRE_W, 4, width of the rate divider

Ports:
clk  in  1  clock; all state changes on rising edge
clear  in  1  reset, asynchronous, active-high
cfg_we  in  1  table write strobe
cfg_addr  in  log2(DEPTH)  table write address
cfg_data  in  WIDTH  table write data
cfg_len  in  log2(DEPTH)+1  run length in entries, sampled on accepted start
div  in  PRE_W  step every div+1 cycles, sampled on accepted start
loop  in  1  1 = wrap to entry 0 after last entry; sampled on accepted start
start  in  1  begin run (level-sampled, acted on only in IDLE)
hold  in  1  freeze stepping while high
stop  in  1  abort run
Q  out  WIDTH  current sequenced state
idx  out  log2(DEPTH)  current table index
busy  out  1  high in RUN or HOLD
done  out  1  one-cycle pulse on one-shot completion
err  out  1  one-cycle pulse on rejected command

Behaviour:
- Reset (clear=1, asynchronous): state=IDLE, Q=1 (binary 001), idx=0, busy=0, done=0, err=0, prescaler=0, table[i]=i for all i.
- All outputs are registered.
- States: IDLE, RUN, HOLD, DONE.
- IDLE:
  - cfg_we=1 writes table[cfg_addr]<=cfg_data.
  - start=1 with 1<=cfg_len<=DEPTH: latch len/div/loop, idx<=0, Q<=table[0], prescaler<=0, go RUN. busy=1 and Q valid the cycle after start.
  - start=1 with cfg_len=0 or cfg_len>DEPTH: err pulse, stay IDLE, Q unchanged.
  - start and cfg_we in the same cycle: the write completes first. If cfg_addr=0, Q takes the new data.
- RUN:
  - Prescaler increments each cycle. When prescaler==div (tick), prescaler<=0 and the sequencer steps.
  - Step with idx<len-1: idx<=idx+1, Q<=table[idx+1].
  - Step with idx==len-1 and loop=1: idx<=0, Q<=table[0].
  - Step with idx==len-1 and loop=0: go DONE, Q and idx hold.
  - div=0 steps every cycle, so entry k is presented k cycles after the first Q update.
  - len=1 with loop=1 repeats table[0] indefinitely.
- HOLD: entered from RUN when hold=1. Prescaler, idx and Q frozen; busy stays 1. hold=0 returns to RUN and the prescaler resumes from its frozen value, so no cycle is lost or gained.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. Q retains the last entry.
- stop=1 in RUN or HOLD: go IDLE next cycle. Q and idx retain values, done not pulsed.
- Priority within a cycle: stop > hold > tick. A tick coinciding with stop or hold is discarded.
- cfg_we while busy: write ignored, err pulse.
- start while busy: ignored, no err.
- Table contents are never altered by a run.
- clear mid-run: immediate return to reset values, table included.

Test Plan:
- Reset: assert clear asynchronously between edges -> Q=001, idx=0, busy=0 immediately. After release, start with cfg_len=8, div=0, loop=0 -> Q=0,1,...,7 on consecutive cycles, done pulses once the cycle after Q=7, Q stays 7.
- Program table {5,3,6,1} at addresses 0-3; start with cfg_len=4, div=2, loop=1 -> Q=5,3,6,1,5,... each held 3 cycles. busy stays 1 and done never pulses.
- During the above with div=2, assert hold for 4 cycles one cycle after a step -> Q frozen for 4 extra cycles, next step occurs exactly 2 cycles after hold falls.
- Assert stop simultaneously with a tick at Q=6 -> next cycle IDLE, busy=0, Q=6, done=0. start with cfg_len=0 -> err=1 for one cycle, Q still 6.
- While busy, pulse cfg_we to address 2 with data 7 -> err pulse. After completion, table[2] is still the original value, checked via a run with cfg_len=3, div=0.
- start with cfg_len=1, loop=0, table[0]=4 -> Q=4 the cycle after start, done pulses the following cycle, busy high for exactly one cycle.

Source files
------------

// File: rtl/seq_counter_ctrl.sv
// Programmable state sequencer: steps Q through a writable table of state codes
// at a divided rate, with one-shot/loop runs, hold, stop and done/err pulses.
module seq_counter_ctrl #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int PRE_W = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [AW:0]      cfg_len,
  input  logic [PRE_W-1:0] div,
  input  logic             loop,
  input  logic             start,
  input  logic             hold,
  input  logic             stop,
  output logic [WIDTH-1:0] Q,
  output logic [AW-1:0]    idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

  state_t           state_r, state_nxt;
  logic [WIDTH-1:0] tbl [DEPTH];
  logic [WIDTH-1:0] q_r, q_nxt;
  logic [AW-1:0]    idx_r, idx_nxt, idx_inc;
  logic [PRE_W-1:0] pre_r, pre_nxt, div_r, div_nxt;
  logic [AW:0]      len_r, len_nxt;
  logic             loop_r, loop_nxt;
  logic             busy_r, done_r, err_r, err_nxt;
  logic             tbl_we, tick, last, len_ok;

  assign idx_inc = idx_r + AW'(1);
  assign tick    = (pre_r == div_r);
  assign last    = ({1'b0, idx_r} == len_r - LEN_ONE);
  assign len_ok  = (cfg_len != '0) && (cfg_len <= LEN_MAX);

  assign Q    = q_r;
  assign idx  = idx_r;
  assign busy = busy_r;
  assign done = done_r;
  assign err  = err_r;

  // Table is only writable from IDLE, so a run can never see it change.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= WIDTH'(i);
    end else if (tbl_we) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_r <= S_IDLE;
      q_r     <= WIDTH'(1);
      idx_r   <= '0;
      pre_r   <= '0;
      div_r   <= '0;
      len_r   <= '0;
      loop_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      q_r     <= q_nxt;
      idx_r   <= idx_nxt;
      pre_r   <= pre_nxt;
      div_r   <= div_nxt;
      len_r   <= len_nxt;
      loop_r  <= loop_nxt;
      busy_r  <= (state_nxt == S_RUN) || (state_nxt == S_HOLD);
      done_r  <= (state_nxt == S_DONE);
      err_r   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state_r;
    unique case (state_r)
      S_IDLE: if (start && len_ok) state_nxt = S_RUN;
      S_RUN, S_HOLD: begin
        if (stop)                       state_nxt = S_IDLE;
        else if (hold)                  state_nxt = S_HOLD;
        else if (tick && last && !loop_r) state_nxt = S_DONE;
        else                            state_nxt = S_RUN;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Leaving HOLD counts as a normal RUN cycle so a hold of N cycles delays by exactly N.
  always_comb begin
    q_nxt    = q_r;
    idx_nxt  = idx_r;
    pre_nxt  = pre_r;
    div_nxt  = div_r;
    len_nxt  = len_r;
    loop_nxt = loop_r;
    err_nxt  = 1'b0;
    tbl_we   = 1'b0;
    unique case (state_r)
      S_IDLE: begin
        tbl_we = cfg_we;
        if (start) begin
          if (len_ok) begin
            len_nxt  = cfg_len;
            div_nxt  = div;
            loop_nxt = loop;
            idx_nxt  = '0;
            pre_nxt  = '0;
            q_nxt    = (cfg_we && (cfg_addr == '0)) ? cfg_data : tbl[0];
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_RUN, S_HOLD: begin
        err_nxt = cfg_we;
        if (!stop && !hold) begin
          if (tick) begin
            pre_nxt = '0;
            if (!last) begin
              idx_nxt = idx_inc;
              q_nxt   = tbl[idx_inc];
            end else if (loop_r) begin
              idx_nxt = '0;
              q_nxt   = tbl[0];
            end
          end else begin
            pre_nxt = pre_r + PRE_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Bench for seq_counter_ctrl: a behavioural model feeds a scoreboard every cycle,
// alongside directed checks of the expected state sequences.
module tb_seq_counter_ctrl;
  localparam int WIDTH = 3;
  localparam int DEPTH = 8;
  localparam int PRE_W = 4;
  localparam int AW    = 3;

  logic             clk = 1'b0, clear = 1'b0;
  logic             cfg_we = 1'b0, loop = 1'b0, start = 1'b0, hold = 1'b0, stop = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  logic [WIDTH-1:0] cfg_data = '0;
  logic [AW:0]      cfg_len = '0;
  logic [PRE_W-1:0] div = '0;
  logic [WIDTH-1:0] Q;
  logic [AW-1:0]    idx;
  logic             busy, done, err;

  always #5 clk = ~clk;

  seq_counter_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PRE_W(PRE_W)) dut (
    .clk(clk), .clear(clear), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_len(cfg_len), .div(div), .loop(loop), .start(start), .hold(hold), .stop(stop),
    .Q(Q), .idx(idx), .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [AW-1:0]    idx;
    logic             busy;
    logic             done;
    logic             err;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  string phase    = "init";

  // model state: 0=IDLE 1=RUN 2=HOLD 3=DONE
  int               m_st;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] m_tbl [DEPTH];
  logic [AW-1:0]    m_idx;
  logic [AW:0]      m_len;
  logic [PRE_W-1:0] m_pre, m_div;
  logic             m_loop, m_err;

  logic [WIDTH-1:0] pat [4] = '{3'd5, 3'd3, 3'd6, 3'd1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
  endtask

  task automatic model_reset();
    m_st = 0; m_q = 3'd1; m_idx = '0; m_pre = '0; m_div = '0; m_len = '0;
    m_loop = 1'b0; m_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = WIDTH'(i);
  endtask

  task automatic model_clock();
    m_err = 1'b0;
    case (m_st)
      0: begin
        if (cfg_we) m_tbl[cfg_addr] = cfg_data;
        if (start) begin
          if (int'(cfg_len) >= 1 && int'(cfg_len) <= DEPTH) begin
            m_len = cfg_len; m_div = div; m_loop = loop;
            m_idx = '0; m_pre = '0; m_q = m_tbl[0]; m_st = 1;
          end else begin
            m_err = 1'b1;
          end
        end
      end
      1, 2: begin
        if (cfg_we) m_err = 1'b1;
        if (stop) m_st = 0;
        else if (hold) m_st = 2;
        else begin
          m_st = 1;
          if (m_pre != m_div) m_pre++;
          else begin
            m_pre = '0;
            if (int'(m_idx) + 1 < int'(m_len)) begin
              m_idx++;
              m_q = m_tbl[m_idx];
            end else if (m_loop) begin
              m_idx = '0;
              m_q = m_tbl[0];
            end else begin
              m_st = 3;
            end
          end
        end
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic step();
    exp_t e;
    exp_t g;
    model_clock();
    e.q = m_q; e.idx = m_idx; e.busy = (m_st == 1 || m_st == 2);
    e.done = (m_st == 3); e.err = m_err;
    sb.push_back(e);
    @(posedge clk); #1;
    g = sb.pop_front();
    chk("sb_q", Q, g.q);
    chk("sb_idx", idx, g.idx);
    chk("sb_busy", busy, g.busy);
    chk("sb_done", done, g.done);
    chk("sb_err", err, g.err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    phase = "reset";
    #2 clear = 1'b1; #1;
    chk("q", Q, 1); chk("idx", idx, 0); chk("busy", busy, 0);
    chk("done", done, 0); chk("err", err, 0);
    model_reset();
    @(posedge clk); #1 clear = 1'b0;

    phase = "seq8";
    cfg_len = 4'd8; div = '0; loop = 1'b0; start = 1'b1;
    step(); chk("q0", Q, 0); chk("busy", busy, 1);
    start = 1'b0;
    for (int i = 1; i < 8; i++) begin step(); chk("qi", Q, i); chk("no_done", done, 0); end
    step(); chk("done", done, 1); chk("q7", Q, 7); chk("busy_off", busy, 0);
    step(); chk("done_off", done, 0); chk("q7_kept", Q, 7);

    phase = "prog";
    cfg_we = 1'b1;
    for (int i = 0; i < 4; i++) begin cfg_addr = AW'(i); cfg_data = pat[i]; step(); end
    cfg_we = 1'b0;

    phase = "loop";
    cfg_len = 4'd4; div = 4'd2; loop = 1'b1; start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 3; c++) begin
        step(); start = 1'b0;
        chk("q", Q, pat[k % 4]); chk("busy", busy, 1); chk("no_done", done, 0);
      end
    end
    step(); chk("q_step", Q, 3);
    step(); chk("q_pre1", Q, 3);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin step(); chk("hold_q", Q, 3); chk("hold_busy", busy, 1); end
    hold = 1'b0;
    step(); chk("after1", Q, 3);
    step(); chk("after2", Q, 6);
    step(); step(); chk("pre2", Q, 6);
    stop = 1'b1;
    step(); chk("stop_busy", busy, 0); chk("stop_q", Q, 6); chk("stop_done", done, 0);
    stop = 1'b0; cfg_len = '0; start = 1'b1;
    step(); chk("len0_err", err, 1); chk("len0_q", Q, 6);
    cfg_len = 4'd9;
    step(); chk("len9_err", err, 1); chk("len9_busy", busy, 0);
    start = 1'b0;
    step(); chk("err_off", err, 0);

    phase = "busy_we";
    cfg_len = 4'd4; div = '0; loop = 1'b0; start = 1'b1;
    step(); start = 1'b0; chk("q", Q, 5);
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 3'd7;
    step(); cfg_we = 1'b0; chk("we_err", err, 1);
    n = 0;
    while (!done && n < 20) begin step(); n++; end
    chk("done_seen", done, 1);
    step();
    cfg_len = 4'd3; start = 1'b1;
    step(); start = 1'b0; chk("r_q0", Q, 5);
    step(); chk("r_q1", Q, 3);
    step(); chk("tbl2_kept", Q, 6);
    step(); chk("r_done", done, 1);
    step();

    phase = "len1";
    cfg_we = 1'b1; cfg_addr = '0; cfg_data = 3'd4; cfg_len = 4'd1; loop = 1'b0; start = 1'b1;
    step(); cfg_we = 1'b0; start = 1'b0;
    chk("q", Q, 4); chk("busy", busy, 1);
    step(); chk("done", done, 1); chk("busy_off", busy, 0); chk("q_kept", Q, 4);
    step(); chk("done_off", done, 0); chk("busy_idle", busy, 0);

    phase = "len1_loop";
    loop = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin step(); chk("q", Q, 4); chk("busy", busy, 1); end

    phase = "clear";
    #3 clear = 1'b1; #1;
    chk("q", Q, 1); chk("idx", idx, 0); chk("busy", busy, 0);
    model_reset();
    @(posedge clk); #1 clear = 1'b0;
    loop = 1'b0; cfg_len = 4'd2; start = 1'b1;
    step(); start = 1'b0; chk("tbl_reset0", Q, 0);
    step(); chk("tbl_reset1", Q, 1);
    step(); chk("done", done, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
